// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the registered 16-bit ALU: 8-entry register file, operand/opcode
// staging and writeback. Optional flag capture (FLAG state, zero_flag) is built with ALU_FLAG_CAPTURE_EN.
module alu_issue_ctrl #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] operand1,
    output logic [DWIDTH-1:0] operand2,
    output logic [3:0]        operation,
    input  logic [DWIDTH-1:0] alu_dout,
    input  logic              alu_z,
    output logic [DWIDTH-1:0] result,
    output logic              zero_flag,
    output logic              done,
    output logic              illegal
);

    localparam int NREGS = 1 << AWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
`ifdef ALU_FLAG_CAPTURE_EN
        ST_CAPTURE = 2'd2,
        ST_FLAG    = 2'd3
`else
        ST_CAPTURE = 2'd2
`endif
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd6);
    endfunction

    state_t            state_r;
    state_t            state_s;
    logic [DWIDTH-1:0] regs_r [NREGS];
    logic [AWIDTH-1:0] rd_r;
    logic [DWIDTH-1:0] operand1_r;
    logic [DWIDTH-1:0] operand2_r;
    logic [3:0]        operation_r;
    logic [DWIDTH-1:0] result_r;
    logic              zero_flag_r;
    logic              done_r;
    logic              illegal_r;

    logic              accept_s;
    logic              legal_s;
    logic              load_s;
    logic              illegal_set_s;
    logic              wb_s;
    logic              flag_s;
    logic              done_set_s;
    logic [2:0]        unused_instr_bits_s;

    assign accept_s            = instr_valid && (state_r == ST_IDLE);
    assign legal_s             = op_legal(instr[15:12]);
    assign unused_instr_bits_s = {instr[11], instr[7], instr[3]};

`ifndef ALU_FLAG_CAPTURE_EN
    logic unused_alu_z_s;
    assign unused_alu_z_s = alu_z;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC:    state_s = ST_CAPTURE;
`ifdef ALU_FLAG_CAPTURE_EN
            ST_CAPTURE: state_s = ST_FLAG;
            ST_FLAG:    state_s = ST_IDLE;
`else
            ST_CAPTURE: state_s = ST_IDLE;
`endif
            default:    state_s = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        load_s        = 1'b0;
        illegal_set_s = 1'b0;
        wb_s          = 1'b0;
        flag_s        = 1'b0;
        done_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s        = legal_s;
                    illegal_set_s = !legal_s;
                end else begin
                    load_s        = 1'b0;
                    illegal_set_s = 1'b0;
                end
            end
            ST_EXEC: begin
                load_s = 1'b0;
            end
            ST_CAPTURE: begin
                wb_s = 1'b1;
`ifndef ALU_FLAG_CAPTURE_EN
                done_set_s = 1'b1;
`endif
            end
`ifdef ALU_FLAG_CAPTURE_EN
            ST_FLAG: begin
                flag_s     = 1'b1;
                done_set_s = 1'b1;
            end
`endif
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Register file: writeback is ordered after the host write so it wins on a shared address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_s && (rd_r == AWIDTH'(i))) begin
                    regs_r[i] <= alu_dout;
                end else if (wr_en && (wr_addr == AWIDTH'(i))) begin
                    regs_r[i] <= wr_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Operand staging; held until the next accept so the ALU output stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand1_r  <= '0;
            operand2_r  <= '0;
            operation_r <= 4'd0;
            rd_r        <= '0;
        end else if (load_s) begin
            operand1_r  <= regs_r[instr[6:4]];
            operand2_r  <= regs_r[instr[2:0]];
            operation_r <= instr[15:12];
            rd_r        <= AWIDTH'(instr[10:8]);
        end else begin
            operand1_r  <= operand1_r;
            operand2_r  <= operand2_r;
            operation_r <= operation_r;
            rd_r        <= rd_r;
        end
    end

    // Result, flag and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r    <= '0;
            zero_flag_r <= 1'b0;
            done_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            done_r    <= done_set_s;
            illegal_r <= illegal_set_s;
            if (wb_s) begin
                result_r <= alu_dout;
            end else begin
                result_r <= result_r;
            end
`ifdef ALU_FLAG_CAPTURE_EN
            if (flag_s) begin
                zero_flag_r <= ~alu_z;
            end else begin
                zero_flag_r <= zero_flag_r;
            end
`else
            zero_flag_r <= flag_s;
`endif
        end
    end

    assign instr_ready = (state_r == ST_IDLE);
    assign rd_data     = regs_r[rd_addr];
    assign operand1    = operand1_r;
    assign operand2    = operand2_r;
    assign operation   = operation_r;
    assign result      = result_r;
    assign zero_flag   = zero_flag_r;
    assign done        = done_r;
    assign illegal     = illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small registered ALU stub; follows ALU_FLAG_CAPTURE_EN.
module tb_alu_issue_ctrl;

`ifdef ALU_FLAG_CAPTURE_EN
    localparam int LAT = 4;
    localparam bit FLAG_ON = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit FLAG_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_ready;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_data = 16'h0000;
    logic [2:0]  rd_addr = 3'd0;
    logic [15:0] rd_data;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic [3:0]  operation;
    logic [15:0] alu_dout = 16'h0000;
    logic        alu_z = 1'b0;
    logic [15:0] result;
    logic        zero_flag;
    logic        done;
    logic        illegal;

    int total = 0;
    int bad = 0;

    alu_issue_ctrl #(.DWIDTH(16), .AWIDTH(3)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .operand1(operand1), .operand2(operand2), .operation(operation),
        .alu_dout(alu_dout), .alu_z(alu_z), .result(result), .zero_flag(zero_flag),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a;
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a << 1;
            4'd4:    return a << 2;
            4'd5:    return a >> 4;
            4'd6:    return a + 16'd1;
            default: return 16'h0000;
        endcase
    endfunction

    // ALU stub: result registered one edge after its inputs, flag one edge after the result.
    always @(posedge clk) begin
        alu_dout <= alu_f(operand1, operand2, operation);
        alu_z    <= (alu_dout != 16'h0000);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] addr, input logic [15:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [2:0] addr, input logic [15:0] exp);
        rd_addr = addr;
        #1;
        chk_eq(tag, {16'h0000, rd_data}, {16'h0000, exp});
    endtask

    // Issue one legal op; optionally collide a host write with its writeback edge.
    task automatic run_op(input logic [15:0] ins, input logic [15:0] exp_res,
                          input bit coll, input logic [2:0] caddr, input logic [15:0] cdata);
        logic [3:0] op;
        logic [2:0] rd;
        logic       exp_zf;
        op = ins[15:12];
        rd = ins[10:8];
        exp_zf = FLAG_ON && (exp_res == 16'h0000);
        @(negedge clk);
        chk_eq("ready_before", {31'd0, instr_ready}, 32'd1);
        instr = ins; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0; instr = 16'hFFFF;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk_eq("done_timing", {31'd0, done}, {31'd0, (c == LAT)});
            chk_eq("operation_hold", {28'd0, operation}, {28'd0, op});
            chk_eq("no_illegal", {31'd0, illegal}, 32'd0);
            if (coll && c == 2) begin
                wr_en = 1'b1; wr_addr = caddr; wr_data = cdata;
            end
            if (c == 3) begin
                wr_en = 1'b0;
            end
        end
        chk_eq("result", {16'h0000, result}, {16'h0000, exp_res});
        chk_eq("zero_flag", {31'd0, zero_flag}, {31'd0, exp_zf});
        read_reg("rd_writeback", rd, exp_res);
    endtask

    initial begin
        // Reset state.
        #12;
        chk_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        chk_eq("rst_result", {16'h0000, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        host_wr(3'd1, 16'h0005);
        host_wr(3'd2, 16'h0003);
        run_op(16'h1312, 16'h0008, 1'b0, 3'd0, 16'h0000);
        run_op(16'h2411, 16'h0000, 1'b0, 3'd0, 16'h0000);

        // Illegal opcode: one-cycle pulse, nothing else moves.
        @(negedge clk);
        instr = 16'h9000; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk_eq("illegal_pulse", {31'd0, illegal}, 32'd1);
        chk_eq("illegal_no_done", {31'd0, done}, 32'd0);
        chk_eq("illegal_ready", {31'd0, instr_ready}, 32'd1);
        @(negedge clk);
        chk_eq("illegal_one_cycle", {31'd0, illegal}, 32'd0);
        chk_eq("illegal_result", {16'h0000, result}, 32'd0);
        chk_eq("illegal_zf", {31'd0, zero_flag}, {31'd0, FLAG_ON});
        read_reg("illegal_r3", 3'd3, 16'h0008);
        read_reg("illegal_r1", 3'd1, 16'h0005);

        run_op(16'h2521, 16'hFFFE, 1'b0, 3'd0, 16'h0000);
        run_op(16'h3610, 16'h000A, 1'b0, 3'd0, 16'h0000);
        run_op(16'h4710, 16'h0014, 1'b0, 3'd0, 16'h0000);
        run_op(16'h5050, 16'h0FFF, 1'b0, 3'd0, 16'h0000);
        run_op(16'h0621, 16'h0003, 1'b0, 3'd0, 16'h0000);
        host_wr(3'd7, 16'hFFFF);
        run_op(16'h6070, 16'h0000, 1'b0, 3'd0, 16'h0000);

        // Back-to-back: valid held high, second op waits for IDLE.
        @(negedge clk);
        instr = 16'h1312; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = 16'h1133;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            chk_eq("b2b_ready", {31'd0, instr_ready}, {31'd0, (c == LAT)});
        end
        @(negedge clk);
        chk_eq("b2b_second_taken", {31'd0, instr_ready}, 32'd0);
        instr_valid = 1'b0;
        for (int c = 2; c <= LAT; c++) begin
            @(negedge clk);
            chk_eq("b2b_done", {31'd0, done}, {31'd0, (c == LAT)});
        end
        read_reg("b2b_r1", 3'd1, 16'h0010);

        // Reset while in CAPTURE.
        @(negedge clk);
        instr = 16'h1312; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_eq("mid_rst_op1", {16'h0000, operand1}, 32'd0);
        chk_eq("mid_rst_op2", {16'h0000, operand2}, 32'd0);
        chk_eq("mid_rst_oper", {28'd0, operation}, 32'd0);
        chk_eq("mid_rst_result", {16'h0000, result}, 32'd0);
        chk_eq("mid_rst_zf", {31'd0, zero_flag}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            read_reg("mid_rst_reg", 3'(a), 16'h0000);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_eq("mid_rst_no_done", {31'd0, done}, 32'd0);
            chk_eq("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        end

        // Host write vs writeback on the same edge.
        host_wr(3'd1, 16'h0005);
        host_wr(3'd2, 16'h0003);
        run_op(16'h1312, 16'h0008, 1'b1, 3'd3, 16'hAAAA);
        run_op(16'h1312, 16'h0008, 1'b1, 3'd6, 16'h1234);
        read_reg("coll_diff_addr", 3'd6, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that sits directly upstream of the 16-bit ALU stage. It accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8-entry register file. It drives the ALU's `operand1`, `operand2` and `operation` inputs, waits out the ALU's registered result and flag latency, and writes the result back to the register file. It also exposes a true-zero flag and a done pulse to the sequencing logic.

## Interface
- `DWIDTH`, 16, data width; must match the ALU.
- `AWIDTH`, 3, register address width; the register file has 2^AWIDTH = 8 entries.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr`  in  16  instruction word:
  - `[15:12]` op
  - `[10:8]` rd
  - `[6:4]` ra
  - `[2:0]` rb
  - bits 11, 7, 3 ignored.
- `instr_ready`  out  1  high only in IDLE.
- `wr_en`  in  1  host register preload strobe.
- `wr_addr`  in  AWIDTH  host write address.
- `wr_data`  in  DWIDTH  host write data.
- `rd_addr`  in  AWIDTH  debug read address.
- `rd_data`  out  DWIDTH  combinational `regfile[rd_addr]`.
- `operand1`  out  DWIDTH  registered; to ALU.
- `operand2`  out  DWIDTH  registered; to ALU.
- `operation`  out  4  registered; to ALU.
- `alu_dout`  in  DWIDTH  ALU result; registered inside the ALU.
- `alu_z`  in  1  ALU flag; high when the ALU result is nonzero.
- `result`  out  DWIDTH  last written-back value.
- `zero_flag`  out  1  high when the last result was zero (inverse of `alu_z`).
- `done`  out  1  one-cycle completion pulse.
- `illegal`  out  1  one-cycle pulse for an unsupported opcode.

## Operation
- **States:** IDLE, EXEC, CAPTURE, FLAG.
- **Legal ops:** 0 pass, 1 add, 2 sub, 3 shl1, 4 shl2, 5 shr4, 6 inc.
  - Ops 7–15 are illegal.
- **IDLE:**
  - Handshake occurs on an edge where `instr_valid && instr_ready`.
  - Legal op: load `operand1=regfile[ra]`, `operand2=regfile[rb]`, `operation=op`; go to EXEC.
  - Illegal op: `illegal` pulses; no register, `result` or `zero_flag` change; stay in IDLE.
- **EXEC:** the ALU registers `dout` on this edge; go to CAPTURE.
- **CAPTURE:** write `regfile[rd]` and `result` with `alu_dout`.
  - Go to FLAG if flag capture is built in, else to IDLE with `done`.
- **FLAG:** the ALU's flag is now valid; set `zero_flag = ~alu_z`; pulse `done`; go to IDLE.
- `operand1`, `operand2` and `operation` hold stable from accept until the next accept. The ALU recomputes every edge, so stable inputs keep its output stable.
- `operand2` is driven from rb even for unary ops; its value is then irrelevant.
- Arithmetic is modulo 2^DWIDTH. Sub underflow wraps; inc of 0xFFFF gives 0.
- **Register file:**
  - Host writes are accepted in any state.
  - If a host write and a writeback target the same address on the same edge, the writeback wins.
  - If they target different addresses, both happen.
- **Reset:**
  - `rst` asserted at any time, including mid-transaction, immediately forces: state IDLE, all registers 0, `operand1`/`operand2`/`operation`/`result` = 0, `zero_flag`/`done`/`illegal` = 0.
  - An in-flight instruction is discarded with no `done`.
  - `instr_ready` is 1 after reset.

## Timing
- Accept edge E0 (legal op): ALU samples operands at E1; writeback at E2; `zero_flag` updates at E3.
- `done` is high for the cycle after E3. `instr_ready` is high in that same cycle, so the next accept can occur at E4.
- Throughput is one instruction per 4 cycles.
- Illegal op: `illegal` is high for the cycle after E0. `done` stays low. The next accept can occur at E1.
- `instr` is sampled only on the accept edge. It may change freely while `instr_ready` is low.
- `done` and `illegal` are never high together.

## Configuration
- Macro: `ALU_FLAG_CAPTURE_EN`.
- Defined: the FLAG state exists and `zero_flag` tracks every legal op. Latency is 4 edges (E0–E3).
- Undefined: the FLAG state is removed and `zero_flag` stays 0.
  - `done` is high for the cycle after E2, and the next accept can occur at E3.
  - `alu_z` is unused.

## Test plan
- Preload r1=5, r2=3 via the host port; issue `0x1312` (add r3=r1+r2):
  - `done` high 4 cycles after accept;
  - r3=8, `result`=8, `zero_flag`=0.
- Issue `0x2411` (sub r4=r1-r1):
  - r4=0, `zero_flag`=1;
  - `operation` reads 2 throughout the transaction.
- Issue `0x2521` (r5=r2-r1):
  - r5=0xFFFE (wraps), `zero_flag`=0.
- Issue `0x9000`:
  - `illegal` high exactly one cycle after accept, `done` stays 0;
  - all registers, `result` and `zero_flag` unchanged;
  - `instr_ready` high the next cycle.
- Assert `rst` while in CAPTURE:
  - all outputs 0 immediately, `rd_data` reads 0 for every address;
  - no `done` pulse; `instr_ready`=1 after release.
- Host write r3=0xAAAA on the same edge as the writeback of add r3=8:
  - r3=8.
- Hold `instr_valid` high with two queued instructions:
  - the second is accepted only at E4 (E3 with the macro undefined).
